// File: rtl/multicycle_ctrl.sv
// Control sequencer for the non-pipelined core: walks each instruction through
// fetch/decode/execute/memory/writeback and owns the imem/dmem handshakes.
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | parked, waiting for run
// FETCH  | imem_req high until imem_ack (or timeout)
// DECODE | decoder outputs settle; illegal/halt resolved here
// EXEC   | ALU capture; branches retire here
// MEM    | dmem_req high until dmem_ack (or timeout); stores retire here
// WB     | register-file write and PC+4; retires
// HALT   | sticky until reset
// FAULT  | sticky until reset (illegal opcode or memory timeout)
module multicycle_ctrl #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             run,
    output logic             imem_req,
    input  logic             imem_ack,
    output logic             ir_load,
    input  logic             dec_load,
    input  logic             dec_store,
    input  logic             dec_branch,
    input  logic             dec_wb,
    input  logic             dec_halt,
    input  logic             dec_illegal,
    input  logic             br_cond,
    output logic             alu_en,
    output logic             pc_we,
    output logic             pc_sel,
    output logic             dmem_req,
    output logic             dmem_we,
    input  logic             dmem_ack,
    output logic             rf_we,
    output logic             rf_wsel,
    output logic             halted,
    output logic             fault,
    output logic [2:0]       state_o,
    output logic [CNT_W-1:0] instret
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6,
        S_FAULT  = 3'd7
    } state_t;

    localparam int unsigned TO_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam int unsigned TO_LIM_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [TO_W-1:0] TO_LIM = TO_LIM_I[TO_W-1:0];
    localparam bit TO_EN = (TIMEOUT != 0);

    state_t           state_q, state_d;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
    logic [CNT_W-1:0] instret_q, instret_d;
    logic             retire;
    logic             to_hit;

    always_comb begin
        state_d  = state_q;
        retire   = 1'b0;
        imem_req = 1'b0;
        ir_load  = 1'b0;
        alu_en   = 1'b0;
        pc_we    = 1'b0;
        pc_sel   = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        rf_we    = 1'b0;
        rf_wsel  = 1'b0;
        halted   = 1'b0;
        fault    = 1'b0;
        to_hit   = TO_EN && (to_cnt_q == TO_LIM);

        case (state_q)
            S_IDLE: begin
                if (run) state_d = S_FETCH;
            end
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    ir_load = 1'b1;
                    state_d = S_DECODE;
                end else if (to_hit) begin
                    state_d = S_FAULT;
                end
            end
            S_DECODE: begin
                if (dec_illegal)   state_d = S_FAULT;
                else if (dec_halt) state_d = S_HALT;
                else               state_d = S_EXEC;
            end
            S_EXEC: begin
                alu_en = 1'b1;
                if (dec_load || dec_store) begin
                    state_d = S_MEM;
                end else if (dec_branch) begin
                    pc_we  = 1'b1;
                    pc_sel = br_cond;
                    retire = 1'b1;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                dmem_req = 1'b1;
                // load+store together behaves as a load, so never write then
                dmem_we  = dec_store & ~dec_load;
                if (dmem_ack) begin
                    if (dec_load) begin
                        state_d = S_WB;
                    end else begin
                        pc_we  = 1'b1;
                        retire = 1'b1;
                    end
                end else if (to_hit) begin
                    state_d = S_FAULT;
                end
            end
            S_WB: begin
                rf_we   = dec_wb;
                rf_wsel = dec_load;
                pc_we   = 1'b1;
                retire  = 1'b1;
            end
            S_HALT:  halted = 1'b1;
            S_FAULT: fault  = 1'b1;
            default: state_d = S_IDLE;
        endcase

        if (retire) state_d = run ? S_FETCH : S_IDLE;

        instret_d = instret_q + CNT_W'(retire);

        // any state change restarts the wait count; it only advances while waiting
        if (state_d != state_q) begin
            to_cnt_d = '0;
        end else if ((state_q == S_FETCH || state_q == S_MEM) && (to_cnt_q != '1)) begin
            to_cnt_d = to_cnt_q + 1'b1;
        end else begin
            to_cnt_d = to_cnt_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            to_cnt_q  <= '0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            to_cnt_q  <= to_cnt_d;
            instret_q <= instret_d;
        end
    end

    assign state_o = state_q;
    assign instret = instret_q;

endmodule
